// File: rtl/sram_port_arbiter.sv
// Shares one single-port 32-bit SRAM between a CPU port (A) and a debug/loader port (B).
// Optional macro SRAM_ARB_LOADER_PRIO_EN: B wins contention, bounded by a starvation counter.
//
// rd_owner state | meaning
// RD_NONE        | no read issued last cycle
// RD_A           | port A read issued last cycle; A_RVALID high now
// RD_B           | port B read issued last cycle; B_RVALID high now
module sram_port_arbiter #(
  parameter int AWIDTH       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [AWIDTH-1:0] A_ADDR,
  input  logic [3:0]        A_BE,
  input  logic [31:0]       A_WDATA,
  output logic              A_GNT,
  output logic              A_RVALID,
  output logic [31:0]       A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [AWIDTH-1:0] B_ADDR,
  input  logic [3:0]        B_BE,
  input  logic [31:0]       B_WDATA,
  output logic              B_GNT,
  output logic              B_RVALID,
  output logic [31:0]       B_RDATA,
  output logic              SRAM_CSN,
  output logic              SRAM_WEN,
  output logic [AWIDTH-1:0] SRAM_ADDR,
  output logic [3:0]        SRAM_BE,
  output logic [31:0]       SRAM_DI,
  input  logic [31:0]       SRAM_DOUT
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_A    = 2'd1,
    RD_B    = 2'd2
  } rd_owner_e;

  rd_owner_e rd_owner_q, rd_owner_d;
  logic      a_win, b_win;

`ifdef SRAM_ARB_LOADER_PRIO_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    a_win        = 1'b0;
    b_win        = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (A_REQ && B_REQ) begin
      if (starve_cnt_q >= CW'(STARVE_LIMIT)) a_win = 1'b1;
      else                                   b_win = 1'b1;
    end else begin
      a_win = A_REQ;
      b_win = B_REQ;
    end
    // a B grant can only happen with A waiting when both request, so this counts A's wait
    if (!A_REQ || a_win)                                  starve_cnt_d = '0;
    else if (b_win && (starve_cnt_q < CW'(STARVE_LIMIT))) starve_cnt_d = starve_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  logic last_owner_q, last_owner_d;  // 1 = B owned the last grant

  always_comb begin
    a_win        = 1'b0;
    b_win        = 1'b0;
    last_owner_d = last_owner_q;
    if (A_REQ && B_REQ) begin
      a_win = last_owner_q;
      b_win = ~last_owner_q;
    end else begin
      a_win = A_REQ;
      b_win = B_REQ;
    end
    if (a_win)      last_owner_d = 1'b0;
    else if (b_win) last_owner_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) last_owner_q <= 1'b1;
    else       last_owner_q <= last_owner_d;
  end
`endif

  // Grants are held off while reset is asserted so the SRAM stays deselected.
  assign A_GNT = RSTN & a_win;
  assign B_GNT = RSTN & b_win;

  always_comb begin
    SRAM_CSN   = 1'b1;
    SRAM_WEN   = 1'b1;
    SRAM_ADDR  = '0;
    SRAM_BE    = '0;
    SRAM_DI    = '0;
    rd_owner_d = RD_NONE;
    if (A_GNT) begin
      SRAM_CSN  = 1'b0;
      SRAM_WEN  = ~A_WE;
      SRAM_ADDR = A_ADDR;
      if (A_WE) begin
        SRAM_BE = A_BE;
        SRAM_DI = A_WDATA;
      end else begin
        rd_owner_d = RD_A;
      end
    end else if (B_GNT) begin
      SRAM_CSN  = 1'b0;
      SRAM_WEN  = ~B_WE;
      SRAM_ADDR = B_ADDR;
      if (B_WE) begin
        SRAM_BE = B_BE;
        SRAM_DI = B_WDATA;
      end else begin
        rd_owner_d = RD_B;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rd_owner_q <= RD_NONE;
    else       rd_owner_q <= rd_owner_d;
  end

  assign A_RVALID = (rd_owner_q == RD_A);
  assign B_RVALID = (rd_owner_q == RD_B);
  assign A_RDATA  = SRAM_DOUT;
  assign B_RDATA  = SRAM_DOUT;

endmodule
